reg_display_fetcher: RTL and testbench
======================================

Name: reg_display_fetcher

Overview:
- Upstream feeder for the board's 8-digit seven-segment register display.
- Selects a CPU register index from pushbuttons or an auto-scan timer and reads it through a req/ack debug read port on the register file.
- Holds the 32-bit value on o_rs for the downstream combinational hex decoder.
- Re-reads periodically so the display tracks a running CPU.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a key level (10 ms at 50 MHz).
- SCAN_CYCLES, 50000000, auto-scan dwell per register in cycles (1 s).
- REFRESH_CYCLES, 1024, cycles spent in HOLD before re-reading the current register.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_key_next  in  1  raw pushbutton, active-low; press advances the index
- i_key_prev  in  1  raw pushbutton, active-low; press decrements the index
- i_auto_scan  in  1  raw slide switch; 1 enables auto-scan
- o_rf_req  out  1  register-file debug read request
- o_rf_addr  out  5  debug read address
- i_rf_ack  in  1  read acknowledge; i_rf_data is valid in the same cycle
- i_rf_data  in  32  read data
- o_rs  out  32  displayed value, to the hex decoder
- o_reg_idx  out  5  currently selected register index
- o_valid  out  1  o_rs holds the value of register o_reg_idx

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset state: o_rs=0, o_reg_idx=0, o_valid=0, o_rf_req=0, o_rf_addr=0. FSM in IDLE, all counters 0, debounced key levels = 1 (released).
- Reset asserted mid-transaction aborts it immediately; no ack is expected after reset.
- Input conditioning:
  - i_key_next, i_key_prev and i_auto_scan each pass through a 2-FF synchronizer.
  - Each key then passes through a debouncer. The accepted level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any mismatch clears the counter.
  - A debounced 1->0 transition produces a single-cycle press pulse. Release produces nothing.
  - The synchronized switch is not debounced.
- Index update (registered):
  - next pulse only: idx+1 mod 32, so 31->0.
  - prev pulse only: idx-1 mod 32, so 0->31.
  - both pulses in the same cycle: no change.
- Auto-scan:
  - While the switch is 1, a scan counter runs 0..SCAN_CYCLES-1. At terminal count, idx increments and the counter returns to 0.
  - A manual press while scanning applies as above and clears the scan counter.
  - Scan counter is held at 0 while the switch is 0.
  - If a scan tick and a prev pulse fall in the same cycle, net change is 0.
- o_valid clears on the same clock edge that o_reg_idx changes.
- FSM states: IDLE, REQ, HOLD.
  - IDLE -> REQ unconditionally, one cycle after reset release.
  - Entering REQ: o_rf_addr latched from idx; o_rf_req=1. o_rf_req and o_rf_addr stay stable until i_rf_ack.
  - REQ, ack with o_rf_addr==idx: o_rs<=i_rf_data, o_valid<=1, o_rf_req<=0, go to HOLD with refresh counter cleared.
  - REQ, ack with o_rf_addr!=idx (index changed mid-request): data discarded, o_valid stays 0, re-enter REQ next cycle with the new address. o_rf_req drops for exactly one cycle.
  - No ack: REQ waits indefinitely; o_valid stays 0 if the index changes meanwhile.
  - HOLD, index change: go to REQ next cycle.
  - HOLD, refresh counter reaches REFRESH_CYCLES-1: go to REQ. o_valid stays 1 during a refresh read and o_rs is replaced on ack.
- Latency: index change to o_valid=1 is at least 2 cycles (1 to REQ, plus ack wait). Minimum REQ occupancy is 1 cycle when i_rf_ack is already high.

Decomposition:
- Package reg_disp_pkg:
  - state enum disp_state_e {IDLE, REQ, HOLD}
  - NREGS=32
  - IDX_W=5
  - DATA_W=32
- Sub-module key_debouncer (parameter DEBOUNCE_CYCLES; ports i_clk, i_rst_n, i_key_n, o_press). Contains the synchronizer, stable counter and press-pulse edge detector. Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_CYCLES=16, REFRESH_CYCLES=8; bench register file acks 2 cycles after req and returns 0xA000_0000+addr):
- Reset release, no input -> o_rf_req rises with o_rf_addr=0; after ack o_rs=0xA000_0000, o_valid=1, o_reg_idx=0; next request 8 cycles later.
- i_key_next low for 3 cycles (glitch) -> no index change. Held low for 10 cycles -> exactly one increment; o_reg_idx=1 then o_rs=0xA000_0001.
- From idx 0, press prev -> o_reg_idx=31, o_rs=0xA000_001F. Press next from 31 -> 0. Both keys pressed simultaneously -> index unchanged.
- i_auto_scan=1 for 64 cycles -> idx steps 0,1,2,3 at 16-cycle spacing, each followed by the matching o_rs.
- Index changed while o_rf_req is high and awaiting ack -> acked data discarded, o_valid stays 0, second request issued for the new index, o_valid=1 only with the matching data.
- i_rst_n asserted while o_rf_req=1 -> all outputs return to reset values asynchronously; after release the sequence restarts from idx 0.

Source files
------------

// File: rtl/reg_disp_pkg.sv
// Shared types and widths for the register display fetcher.
package reg_disp_pkg;

   localparam int unsigned NREGS  = 32;
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } disp_state_e;

   // Net index step: +1 for next, +1 for a scan tick, -1 for prev, wrapping mod NREGS.
   function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx,
                                                 input logic             inc,
                                                 input logic             dec,
                                                 input logic             tick);
      logic [IDX_W-1:0] r;
      r = idx + IDX_W'(inc) + IDX_W'(tick) - IDX_W'(dec);
      return r;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability counter and
// single-cycle press pulse on an accepted 1->0 transition.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the accepted level; flip on the last one.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      press_d = level_q & ~level_d;
   end

   // Synchronizer, debounce state and press pulse registers; keys reset as released.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= i_key_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign o_press = press_q;

endmodule

// File: rtl/reg_display_fetcher.sv
// Selects a register index from keys or auto-scan, fetches it over the debug read
// port and holds the value for the seven-segment hex decoder.
module reg_display_fetcher
   import reg_disp_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SCAN_CYCLES     = 50000000,
   parameter int unsigned REFRESH_CYCLES  = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_key_next,
   input  logic              i_key_prev,
   input  logic              i_auto_scan,
   output logic              o_rf_req,
   output logic [IDX_W-1:0]  o_rf_addr,
   input  logic              i_rf_ack,
   input  logic [DATA_W-1:0] i_rf_data,
   output logic [DATA_W-1:0] o_rs,
   output logic [IDX_W-1:0]  o_reg_idx,
   output logic              o_valid
);

   localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);
   localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES + 1);

   logic              press_next, press_prev;
   logic              auto_s1_q, auto_s2_q;
   logic              scan_tick, idx_change, ack_match;

   disp_state_e       state_q, state_d;
   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [REF_W-1:0]  refresh_q, refresh_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] rs_q, rs_d;
   logic              valid_q, valid_d;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_next (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_key_n(i_key_next),
      .o_press(press_next)
   );

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_prev (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_key_n(i_key_prev),
      .o_press(press_prev)
   );

   // Index selection, scan timer and fetch FSM next-state.
   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      refresh_d = refresh_q;
      addr_d    = addr_q;
      req_d     = req_q;
      rs_d      = rs_q;
      valid_d   = valid_q;

      scan_tick = auto_s2_q && (scan_q == SCAN_W'(SCAN_CYCLES - 1));
      if (!auto_s2_q || press_next || press_prev || scan_tick) begin
         scan_d = '0;
      end else begin
         scan_d = scan_q + SCAN_W'(1);
      end

      idx_d      = idx_step(idx_q, press_next, press_prev, scan_tick);
      idx_change = (idx_d != idx_q);
      // Data is only good if it belongs to the index that will still be shown after this edge.
      ack_match  = (addr_q == idx_q) && !idx_change;

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = idx_d;
         end
         REQ: begin
            if (i_rf_ack) begin
               req_d = 1'b0;
               if (ack_match) begin
                  rs_d      = i_rf_data;
                  valid_d   = 1'b1;
                  refresh_d = '0;
                  state_d   = HOLD;
               end else begin
                  // Stale data: drop req for one cycle and re-issue for the new index.
                  state_d = IDLE;
               end
            end
         end
         HOLD: begin
            if (idx_change || (refresh_q == REF_W'(REFRESH_CYCLES - 1))) begin
               state_d   = REQ;
               req_d     = 1'b1;
               addr_d    = idx_d;
               refresh_d = '0;
            end else begin
               refresh_d = refresh_q + REF_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase

      if (idx_change) begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset aborts any outstanding request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         auto_s1_q <= 1'b0;
         auto_s2_q <= 1'b0;
         state_q   <= IDLE;
         scan_q    <= '0;
         refresh_q <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         req_q     <= 1'b0;
         rs_q      <= '0;
         valid_q   <= 1'b0;
      end else begin
         auto_s1_q <= i_auto_scan;
         auto_s2_q <= auto_s1_q;
         state_q   <= state_d;
         scan_q    <= scan_d;
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         rs_q      <= rs_d;
         valid_q   <= valid_d;
      end
   end

   assign o_rf_req  = req_q;
   assign o_rf_addr = addr_q;
   assign o_rs      = rs_q;
   assign o_reg_idx = idx_q;
   assign o_valid   = valid_q;

endmodule

// File: tb/tb_reg_display_fetcher.sv
// Randomized and directed bench for reg_display_fetcher with a behavioural index model
// and a register file that answers 0xA000_0000 + addr two cycles after a request.
module tb_reg_display_fetcher;

   localparam int DEB  = 4;
   localparam int SCAN = 16;
   localparam int REFR = 8;
   localparam logic [31:0] BASE = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_next = 1'b1;
   logic        key_prev = 1'b1;
   logic        auto_scan = 1'b0;
   logic        rf_ack = 1'b0;
   logic [31:0] rf_data = 32'h0;
   logic        rf_req;
   logic [4:0]  rf_addr;
   logic [31:0] rs;
   logic [4:0]  reg_idx;
   logic        valid;

   int total = 0;
   int bad = 0;
   bit rf_stall = 1'b0;

   always #5 clk = ~clk;

   reg_display_fetcher #(
      .DEBOUNCE_CYCLES(DEB),
      .SCAN_CYCLES    (SCAN),
      .REFRESH_CYCLES (REFR)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_key_next (key_next),
      .i_key_prev (key_prev),
      .i_auto_scan(auto_scan),
      .o_rf_req   (rf_req),
      .o_rf_addr  (rf_addr),
      .i_rf_ack   (rf_ack),
      .i_rf_data  (rf_data),
      .o_rs       (rs),
      .o_reg_idx  (reg_idx),
      .o_valid    (valid)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural index model ----------------
   // A key level is accepted once the last DEB synchronized samples all disagree with it.
   bit m_p1[2], m_p2[2];
   bit m_win[2][DEB];
   bit m_level[2];
   bit m_pend[2];
   bit m_a1, m_a2;
   int m_scan, m_idx, m_stable;
   bit m_changed;

   always @(posedge clk or negedge rst_n) begin
      bit raw[2];
      bit a_s, tick, s, all_diff;
      int old;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_p1[k] = 1'b1;
            m_p2[k] = 1'b1;
            m_level[k] = 1'b1;
            m_pend[k] = 1'b0;
            for (int j = 0; j < DEB; j++) m_win[k][j] = 1'b1;
         end
         m_a1 = 1'b0;
         m_a2 = 1'b0;
         m_scan = 0;
         m_idx = 0;
         m_stable = 0;
         m_changed = 1'b0;
      end else begin
         raw[0] = key_next;
         raw[1] = key_prev;
         a_s = m_a2;
         m_a2 = m_a1;
         m_a1 = auto_scan;
         tick = a_s && (m_scan == SCAN - 1);
         if (!a_s || m_pend[0] || m_pend[1] || tick) m_scan = 0;
         else m_scan = m_scan + 1;
         old = m_idx;
         m_idx = (m_idx + 32 + int'(m_pend[0]) - int'(m_pend[1]) + int'(tick)) % 32;
         m_changed = (m_idx != old);
         m_stable = m_changed ? 0 : m_stable + 1;
         for (int k = 0; k < 2; k++) begin
            s = m_p2[k];
            m_p2[k] = m_p1[k];
            m_p1[k] = raw[k];
            for (int j = DEB - 1; j > 0; j--) m_win[k][j] = m_win[k][j-1];
            m_win[k][0] = s;
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (m_win[k][j] == m_level[k]) all_diff = 1'b0;
            m_pend[k] = 1'b0;
            if (all_diff) begin
               m_pend[k] = m_level[k];
               m_level[k] = ~m_level[k];
            end
         end
      end
   end

   // ---------------- per-cycle compare and register file ----------------
   bit          prev_req = 1'b0;
   bit          prev_ack = 1'b0;
   logic [4:0]  prev_addr = '0;
   int          rf_cnt = 0;
   int          since_stall = 100;

   always @(negedge clk) begin
      if (!rst_n) begin
         rf_cnt = 0;
         rf_ack = 1'b0;
         prev_req = 1'b0;
         prev_ack = 1'b0;
      end else begin
         check("idx", 32'(reg_idx), 32'(m_idx));
         if (valid) check("rs_of_idx", rs, BASE + 32'(reg_idx));
         if (m_changed) check("valid_clear", 32'(valid), 32'd0);
         if (prev_req && !prev_ack) begin
            check("req_hold", 32'(rf_req), 32'd1);
            check("addr_hold", 32'(rf_addr), 32'(prev_addr));
         end
         if (m_stable >= 6 && since_stall >= 8) check("live_valid", 32'(valid), 32'd1);
         if (rf_req && !rf_stall) rf_cnt++;
         else rf_cnt = 0;
         if (rf_cnt >= 2) begin
            rf_ack = 1'b1;
            rf_data = BASE + 32'(rf_addr);
         end else begin
            rf_ack = 1'b0;
            rf_data = $urandom;
         end
         since_stall = rf_stall ? 0 : (since_stall < 100 ? since_stall + 1 : 100);
         prev_req = rf_req;
         prev_addr = rf_addr;
         prev_ack = rf_ack;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_req(input logic lvl, input int bound, input string name);
      int n = 0;
      while (rf_req !== lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(rf_req), 32'(lvl));
   endtask

   task automatic wait_valid(input int bound, input string name);
      int n = 0;
      while (valid !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(valid), 32'd1);
   endtask

   task automatic press(input bit nxt, input bit prv, input int cycles);
      @(negedge clk);
      key_next = ~nxt;
      key_prev = ~prv;
      repeat (cycles) @(negedge clk);
      key_next = 1'b1;
      key_prev = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, steps, last_idx, last_t;
      int hold[2];
      int stall_len;

      repeat (3) @(negedge clk);
      check("rst_rs", rs, 32'd0);
      check("rst_idx", 32'(reg_idx), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_req", 32'(rf_req), 32'd0);
      check("rst_addr", 32'(rf_addr), 32'd0);
      rst_n = 1'b1;

      // First fetch and refresh spacing
      wait_req(1'b1, 10, "first_req");
      check("first_addr", 32'(rf_addr), 32'd0);
      wait_valid(10, "first_valid");
      check("first_rs", rs, 32'hA000_0000);
      check("first_idx", 32'(reg_idx), 32'd0);
      n = 0;
      while (!rf_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("refresh_gap", 32'(n), 32'd8);

      // Glitch, then a real press
      press(1'b1, 1'b0, 3);
      check("glitch_idx", 32'(reg_idx), 32'd0);
      press(1'b1, 1'b0, 10);
      check("next_idx", 32'(reg_idx), 32'd1);
      check("next_rs", rs, 32'hA000_0001);
      press(1'b0, 1'b1, 10);
      check("prev_idx0", 32'(reg_idx), 32'd0);
      press(1'b0, 1'b1, 10);
      check("prev_wrap_idx", 32'(reg_idx), 32'd31);
      check("prev_wrap_rs", rs, 32'hA000_001F);
      press(1'b1, 1'b0, 10);
      check("next_wrap_idx", 32'(reg_idx), 32'd0);
      press(1'b1, 1'b1, 10);
      check("both_idx", 32'(reg_idx), 32'd0);

      // Auto-scan: three ticks 16 cycles apart
      steps = 0;
      last_idx = 0;
      last_t = -1;
      @(negedge clk);
      auto_scan = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (32'(reg_idx) != 32'(last_idx)) begin
            steps++;
            check("scan_step", 32'(reg_idx), 32'((last_idx + 1) % 32));
            if (last_t >= 0) check("scan_spacing", 32'(c - last_t), 32'd16);
            last_idx = int'(reg_idx);
            last_t = c;
         end
      end
      auto_scan = 1'b0;
      check("scan_steps", 32'(steps), 32'd3);
      repeat (10) @(negedge clk);
      check("scan_rs", rs, 32'hA000_0003);

      // Index change while a request is outstanding
      rf_stall = 1'b1;
      wait_req(1'b1, 12, "stall_req");
      check("stall_addr", 32'(rf_addr), 32'd3);
      key_next = 1'b0;
      n = 0;
      while (reg_idx == 5'd3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      key_next = 1'b1;
      check("mid_idx", 32'(reg_idx), 32'd4);
      check("mid_valid", 32'(valid), 32'd0);
      check("mid_req", 32'(rf_req), 32'd1);
      check("mid_addr", 32'(rf_addr), 32'd3);
      repeat (3) @(negedge clk);
      rf_stall = 1'b0;
      wait_req(1'b0, 8, "stale_drop");
      check("stale_valid", 32'(valid), 32'd0);
      n = 0;
      while (!rf_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("drop_len", 32'(n), 32'd1);
      check("retry_addr", 32'(rf_addr), 32'd4);
      wait_valid(8, "retry_valid");
      check("retry_rs", rs, 32'hA000_0004);

      // Reset in the middle of a request
      rf_stall = 1'b1;
      wait_req(1'b1, 12, "rst_mid_req");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_rs", rs, 32'd0);
      check("arst_idx", 32'(reg_idx), 32'd0);
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_req", 32'(rf_req), 32'd0);
      check("arst_addr", 32'(rf_addr), 32'd0);
      repeat (3) @(negedge clk);
      rf_stall = 1'b0;
      rst_n = 1'b1;
      wait_req(1'b1, 10, "restart_req");
      check("restart_addr", 32'(rf_addr), 32'd0);
      wait_valid(10, "restart_valid");
      check("restart_rs", rs, 32'hA000_0000);

      // Randomized keys, switch and register-file stalls
      hold[0] = 0;
      hold[1] = 0;
      stall_len = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (hold[k] == 0) begin
               hold[k] = int'($urandom_range(1, 12));
               if (k == 0) key_next = ($urandom_range(0, 1) == 0);
               else key_prev = ($urandom_range(0, 1) == 0);
            end else begin
               hold[k]--;
            end
         end
         if ($urandom_range(0, 299) == 0) auto_scan = ~auto_scan;
         if (stall_len > 0) begin
            stall_len--;
            rf_stall = 1'b1;
         end else begin
            rf_stall = 1'b0;
            if ($urandom_range(0, 99) == 0) stall_len = int'($urandom_range(1, 15));
         end
      end
      key_next = 1'b1;
      key_prev = 1'b1;
      auto_scan = 1'b0;
      rf_stall = 1'b0;
      repeat (30) @(negedge clk);
      check("final_valid", 32'(valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
